// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_pkg
// Purpose  : Shared AHB-Lite codes, RAM-slave FSM encoding and strobe decode.
// Revision : 1.0  initial release
// ============================================================================
package ahb_lite_pkg;

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  localparam logic [2:0] c_hsize_byte = 3'd0;
  localparam logic [2:0] c_hsize_half = 3'd1;
  localparam logic [2:0] c_hsize_word = 3'd2;

  localparam logic c_hresp_okay  = 1'b0;
  localparam logic c_hresp_error = 1'b1;

  typedef enum logic [1:0] {
    c_st_idle    = 2'd0,
    c_st_rd_wait = 2'd1,
    c_st_err1    = 2'd2,
    c_st_err2    = 2'd3
  } state_t;

  function automatic logic [3:0] strb_decode(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      c_hsize_byte: strb_decode = 4'b0001 << addr_lo;
      c_hsize_half: strb_decode = addr_lo[1] ? 4'b1100 : 4'b0011;
      c_hsize_word: strb_decode = 4'b1111;
      default:      strb_decode = 4'b0000;
    endcase
  endfunction

  // Oversized or misaligned transfers are illegal.
  function automatic logic xfer_illegal(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      c_hsize_byte: xfer_illegal = 1'b0;
      c_hsize_half: xfer_illegal = addr_lo[0];
      c_hsize_word: xfer_illegal = |addr_lo;
      default:      xfer_illegal = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Purpose  : 32-bit simple-dual-port RAM, byte-enabled write, read-first read,
//            optional second output register stage.
// Revision : 1.0  initial release
// ============================================================================
module sdp_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [3:0]            i_wstrb,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_q1;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_wstrb[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // The read register only moves on a read so the slave output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= '0;
    end else if (i_re) begin
      r_q1 <= r_mem[i_raddr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        r_re_d;
      logic [31:0] r_q2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_re_d <= 1'b0;
          r_q2   <= '0;
        end else begin
          r_re_d <= i_re;
          if (r_re_d) begin
            r_q2 <= r_q1;
          end
        end
      end
      assign o_rdata = r_q2;
    end else begin : g_no_out_reg
      assign o_rdata = r_q1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ahb_lite_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_ram_pipe
// Purpose  : AHB-Lite memory slave over sdp_ram with write-to-read forwarding.
//            Define AHB_RAM_ERR_EN for two-cycle ERROR on illegal transfers.
// Revision : 1.0  initial release
// ============================================================================
module ahb_lite_ram_pipe
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int OUT_REG    = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  logic                  w_acc;
  logic                  w_illegal;
  logic                  w_legal_wr;
  logic                  w_legal_rd;
  logic                  w_rd_upd;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [3:0]            w_strb;
  logic [31:0]           w_ram_q;
  logic                  w_unused;

  logic                  r_pw_valid;
  logic [ADDR_WIDTH-1:0] r_pw_addr;
  logic [3:0]            r_pw_strb;
  logic                  r_fwd;
  logic                  r_zero;
  logic [31:0]           r_fwd_data;
  logic [3:0]            r_fwd_strb;

  state_t                r_state;
  state_t                w_state_nxt;
  state_t                w_dec_state;

  assign w_acc      = HSEL & HREADY & ((HTRANS == c_htrans_nonseq) | (HTRANS == c_htrans_seq));
  assign w_word     = HADDR[ADDR_WIDTH+1:2];
  assign w_strb     = strb_decode(HADDR[1:0], HSIZE);
  assign w_illegal  = xfer_illegal(HADDR[1:0], HSIZE);
  assign w_legal_wr = w_acc & HWRITE & ~w_illegal;
  assign w_legal_rd = w_acc & ~HWRITE & ~w_illegal;
  assign w_ram_we   = r_pw_valid & ~HRESET;
  assign w_unused   = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};

`ifdef AHB_RAM_ERR_EN
  assign w_rd_upd = w_legal_rd;
`else
  // Illegal reads still complete and must present zero data.
  assign w_rd_upd = w_acc & ~HWRITE;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pw_valid <= 1'b0;
      r_pw_addr  <= '0;
      r_pw_strb  <= '0;
    end else begin
      r_pw_valid <= w_legal_wr;
      if (w_legal_wr) begin
        r_pw_addr <= w_word;
        r_pw_strb <= w_strb;
      end
    end
  end

  // Read-first RAM returns stale data when the pending write lands on the same word.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_fwd      <= 1'b0;
      r_zero     <= 1'b0;
      r_fwd_data <= '0;
      r_fwd_strb <= '0;
    end else if (w_rd_upd) begin
      r_fwd      <= w_legal_rd & r_pw_valid & (r_pw_addr == w_word);
      r_zero     <= w_illegal;
      r_fwd_data <= HWDATA;
      r_fwd_strb <= r_pw_strb;
    end
  end

  sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_ram (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_we    (w_ram_we),
    .i_waddr (r_pw_addr),
    .i_wstrb (r_pw_strb),
    .i_wdata (HWDATA),
    .i_re    (w_legal_rd),
    .i_raddr (w_word),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    HRDATA = w_ram_q;
    for (int b = 0; b < 4; b++) begin
      if (r_fwd && r_fwd_strb[b]) begin
        HRDATA[8*b +: 8] = r_fwd_data[8*b +: 8];
      end
    end
    if (r_zero) begin
      HRDATA = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_dec_state = c_st_idle;
    if (w_legal_rd && (OUT_REG != 0)) begin
      w_dec_state = c_st_rd_wait;
    end
`ifdef AHB_RAM_ERR_EN
    if (w_acc && w_illegal) begin
      w_dec_state = c_st_err1;
    end
`endif
  end

  always_comb begin
    w_state_nxt = c_st_idle;
    HREADYOUT   = 1'b1;
    HRESP       = c_hresp_okay;
    case (r_state)
      c_st_rd_wait: begin
        HREADYOUT = 1'b0;
      end
`ifdef AHB_RAM_ERR_EN
      c_st_err1: begin
        HREADYOUT   = 1'b0;
        HRESP       = c_hresp_error;
        w_state_nxt = c_st_err2;
      end
      c_st_err2: begin
        HRESP       = c_hresp_error;
        w_state_nxt = w_dec_state;
      end
`endif
      default: begin
        w_state_nxt = w_dec_state;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_ram_pipe
// Purpose  : Two slaves on one bus (OUT_REG=0 and OUT_REG=1) driven by a
//            pipelined master, checked against a word-array memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_ram_pipe;
  import ahb_lite_pkg::*;

  localparam int AW    = 12;
  localparam int LIMIT = 5000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        hsel = 1'b0;
  logic        tsel = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = c_htrans_idle;
  logic [2:0]  HSIZE = '0;
  logic [3:0]  HPROT = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  ready_o;
  logic [1:0]  resp_o;
  logic [31:0] rdata0, rdata1;
  logic        w_hready, w_resp;
  logic [31:0] w_rdata;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] mem [2][16];
  logic [31:0] last_rd [2];
  logic [31:0] last_obs;
  xfer_t       q[$];

  assign w_hready = tsel ? ready_o[1] : ready_o[0];
  assign w_resp   = tsel ? resp_o[1]  : resp_o[0];
  assign w_rdata  = tsel ? rdata1     : rdata0;

  always #5 HCLK = ~HCLK;

  ahb_lite_ram_pipe #(.ADDR_WIDTH(AW), .OUT_REG(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & ~tsel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(w_hready),
    .HREADYOUT(ready_o[0]), .HRDATA(rdata0), .HRESP(resp_o[0])
  );

  ahb_lite_ram_pipe #(.ADDR_WIDTH(AW), .OUT_REG(1)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & tsel), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(w_hready),
    .HREADYOUT(ready_o[1]), .HRDATA(rdata1), .HRESP(resp_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (slave %0d): got 0x%08h, expected 0x%08h", tag, tsel, obs, exp);
  endtask

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] data);
    xfer_t x;
    x.sel = 1'b1; x.trans = c_htrans_nonseq; x.wr = wr;
    x.addr = addr; x.size = size; x.data = data;
    return x;
  endfunction

  function automatic xfer_t idle_x();
    xfer_t x;
    x.sel = 1'b0; x.trans = c_htrans_idle; x.wr = 1'b0;
    x.addr = '0; x.size = '0; x.data = '0;
    return x;
  endfunction

  function automatic bit is_xfer(input xfer_t x);
    return x.sel && (x.trans == c_htrans_nonseq || x.trans == c_htrans_seq);
  endfunction

  // Legal means size at most a word and the address a multiple of the size in bytes.
  function automatic bit is_illegal(input xfer_t x);
    int nb;
    if (x.size > 3'd2) return 1'b1;
    nb = 1 << x.size;
    return (int'(x.addr[1:0]) % nb) != 0;
  endfunction

  task automatic drive(input xfer_t x);
    hsel   = x.sel;
    HTRANS = x.trans;
    HWRITE = x.wr;
    HADDR  = x.addr;
    HSIZE  = x.size;
    HPROT  = 4'($urandom);
  endtask

  task automatic complete(input xfer_t x, input int waits);
    bit          ill;
    int          w, nb, ln, exp_waits;
    logic        exp_resp;
    logic [31:0] exp;
    ill       = is_illegal(x);
    w         = int'(x.addr[5:2]);
    exp_resp  = 1'b0;
    // Slave 1 is built with the output register: one wait per legal read.
    exp_waits = (!x.wr && !ill && tsel) ? 1 : 0;
`ifdef AHB_RAM_ERR_EN
    if (ill) begin
      exp_resp  = 1'b1;
      exp_waits = 1;
    end
`endif
    check_eq("resp", {31'd0, w_resp}, {31'd0, exp_resp});
    check_eq("waits", 32'(waits), 32'(exp_waits));
    if (x.wr) begin
      if (!ill) begin
        nb = 1 << x.size;
        for (int k = 0; k < nb; k++) begin
          ln = int'(x.addr[1:0]) + k;
          mem[tsel][w][ln*8 +: 8] = x.data[ln*8 +: 8];
        end
      end
      check_eq("rdata_hold", w_rdata, last_rd[tsel]);
    end else begin
      if (!ill) exp = mem[tsel][w];
`ifdef AHB_RAM_ERR_EN
      else exp = last_rd[tsel];
`else
      else exp = 32'h0;
`endif
      check_eq("rdata", w_rdata, exp);
      last_rd[tsel] = exp;
      last_obs = w_rdata;
    end
  endtask

  // Pipelined master: address phase of the next transfer overlaps the current data phase.
  task automatic run_q();
    xfer_t ap, dp;
    bit    dp_v;
    int    waits, guard;
    logic  rdy, er;
    dp_v = 1'b0; waits = 0; guard = 0;
    if (q.size() != 0) ap = q.pop_front(); else ap = idle_x();
    drive(ap);
    while ((q.size() != 0 || is_xfer(ap) || dp_v) && guard < LIMIT) begin
      @(negedge HCLK);
      rdy = w_hready;
      if (dp_v) begin
        if (rdy) complete(dp, waits);
        else begin
          waits++;
          er = 1'b0;
`ifdef AHB_RAM_ERR_EN
          er = is_illegal(dp);
`endif
          check_eq("wait_resp", {31'd0, w_resp}, {31'd0, er});
        end
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        dp_v  = is_xfer(ap);
        dp    = ap;
        waits = 0;
        if (q.size() != 0) ap = q.pop_front(); else ap = idle_x();
        drive(ap);
        HWDATA = (dp_v && dp.wr) ? dp.data : $urandom;
      end
      guard++;
    end
    if (guard >= LIMIT) check_eq("timeout", 32'(guard), 32'd0);
  endtask

  task automatic reset_checks();
    for (int s = 0; s < 2; s++) last_rd[s] = 32'h0;
    @(negedge HCLK);
    check_eq("rst_ready0", {31'd0, ready_o[0]}, 32'd1);
    check_eq("rst_ready1", {31'd0, ready_o[1]}, 32'd1);
    check_eq("rst_resp0", {31'd0, resp_o[0]}, 32'd0);
    check_eq("rst_resp1", {31'd0, resp_o[1]}, 32'd0);
    check_eq("rst_rdata0", rdata0, 32'd0);
    check_eq("rst_rdata1", rdata1, 32'd0);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    xfer_t x;
    drive(idle_x());
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    reset_checks();

    for (int s = 0; s < 2; s++) begin
      tsel = (s == 1);
      for (int i = 0; i < 16; i++) q.push_back(mk(1'b1, 32'(i * 4), c_hsize_word, $urandom));
      run_q();

      q.push_back(mk(1'b1, 32'h10, c_hsize_word, 32'hDEADBEEF));
      q.push_back(mk(1'b0, 32'h10, c_hsize_word, 32'h0));
      run_q();
      check_eq("plan_word_rd", last_obs, 32'hDEADBEEF);

      q.push_back(mk(1'b1, 32'h10, c_hsize_word, 32'h0));
      q.push_back(mk(1'b1, 32'h11, c_hsize_byte, 32'hAAAAAAAA));
      q.push_back(mk(1'b0, 32'h10, c_hsize_word, 32'h0));
      run_q();
      check_eq("plan_fwd_byte", last_obs, 32'h0000AA00);

      q.push_back(mk(1'b1, 32'h20, c_hsize_word, 32'h12345678));
      q.push_back(idle_x());
      q.push_back(mk(1'b0, 32'h20, c_hsize_word, 32'h0));
      run_q();
      check_eq("plan_rd_20", last_obs, 32'h12345678);

      q.push_back(mk(1'b1, 32'h21, c_hsize_half, 32'hFFFFFFFF));
      q.push_back(mk(1'b0, 32'h20, c_hsize_word, 32'h0));
      run_q();
      check_eq("plan_bad_half_wr", last_obs, 32'h12345678);

      q.push_back(mk(1'b0, 32'h20, 3'd3, 32'h0));
      run_q();
`ifdef AHB_RAM_ERR_EN
      check_eq("plan_size3_rd", last_obs, 32'h12345678);
`else
      check_eq("plan_size3_rd", last_obs, 32'h0);
`endif

      // Reset lands in the data phase of a write; the write must vanish.
      q.push_back(mk(1'b1, 32'h30, c_hsize_word, 32'h11223344));
      run_q();
      drive(mk(1'b1, 32'h30, c_hsize_word, 32'h0));
      @(posedge HCLK);
      #1;
      drive(idle_x());
      HWDATA = 32'h55;
      HRESET = 1'b1;
      @(posedge HCLK);
      #1 HRESET = 1'b0;
      reset_checks();
      q.push_back(mk(1'b0, 32'h30, c_hsize_word, 32'h0));
      run_q();
      check_eq("plan_rst_drop", last_obs, 32'h11223344);

      for (int i = 0; i < 250; i++) begin
        x.sel   = ($urandom_range(0, 9) != 0);
        x.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        x.wr    = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
        x.data  = $urandom;
        q.push_back(x);
      end
      run_q();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
